// File: rtl/decode_queue.sv
// decode_queue: decodes RV64 instructions as they are accepted and buffers the
// decoded fields in a DEPTH-entry FIFO for the issue stage.
//
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   flush_i                      discard every queued entry at the next edge
//   instr_valid_i/instr_ready_o  input handshake
//   instruction_i, pc_i          instruction word and its PC
//   out_valid_o/out_ready_i      output handshake for the head entry
//   out_pc_o, out_rs1_o, out_rs2_o, out_rd_o, out_op_o, out_fu_o, out_illegal_o
//                                decoded fields of the head entry
//   count_o                      occupied entries
//   decoded_cnt_o, illegal_cnt_o saturating accepted / illegal instruction counts

package decode_queue_pkg;

   typedef enum logic [2:0] {
      FuNone,
      FuAlu,
      FuMult,
      FuLoad,
      FuStore
   } fu_t;

   // OpAdd must stay at encoding 0 so that zeroed storage reads back as ADD.
   typedef enum logic [5:0] {
      OpAdd,
      OpSub,
      OpSll,
      OpSlts,
      OpSltu,
      OpXorl,
      OpSrl,
      OpSra,
      OpOrl,
      OpAndl,
      OpMul,
      OpMulh,
      OpMulhsu,
      OpMulhu,
      OpDiv,
      OpDivu,
      OpRem,
      OpRemu,
      OpAddw,
      OpSllw,
      OpSrlw,
      OpSraw,
      OpLb,
      OpLh,
      OpLw,
      OpLd,
      OpLbu,
      OpLhu,
      OpLwu,
      OpSb,
      OpSh,
      OpSw,
      OpSd
   } fu_op;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      fu_op        op;
      fu_t         fu;
      logic        illegal;
   } entry_t;

   localparam entry_t EmptyEntry = '{
      pc:      64'h0,
      rs1:     5'd0,
      rs2:     5'd0,
      rd:      5'd0,
      op:      OpAdd,
      fu:      FuNone,
      illegal: 1'b0
   };

endpackage

module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush_i,
   input  logic                         instr_valid_i,
   output logic                         instr_ready_o,
   input  logic [31:0]                  instruction_i,
   input  logic [63:0]                  pc_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [63:0]                  out_pc_o,
   output logic [4:0]                   out_rs1_o,
   output logic [4:0]                   out_rs2_o,
   output logic [4:0]                   out_rd_o,
   output fu_op                         out_op_o,
   output fu_t                          out_fu_o,
   output logic                         out_illegal_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [CNT_W-1:0]             decoded_cnt_o,
   output logic [CNT_W-1:0]             illegal_cnt_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOp32   = 7'b0011011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] F7Base    = 7'b0000000;
   localparam logic [6:0] F7Alt     = 7'b0100000;
   localparam logic [6:0] F7MulDiv  = 7'b0000001;

   entry_t                mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q;
   logic [PtrW-1:0]       rd_ptr_q;
   logic [CntW-1:0]       count_q;
   logic [CNT_W-1:0]      decoded_cnt_q;
   logic [CNT_W-1:0]      illegal_cnt_q;

   entry_t                dec;
   entry_t                head;
   logic                  legal;
   logic                  push;
   logic                  pop;

   logic [6:0]            opc;
   logic [2:0]            f3;
   logic [6:0]            f7;

   assign opc = instruction_i[6:0];
   assign f3  = instruction_i[14:12];
   assign f7  = instruction_i[31:25];

   // ------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ------------------------------------------------------------------
   always_comb begin
      legal       = 1'b0;
      dec.pc      = pc_i;
      dec.rs1     = instruction_i[19:15];
      dec.rs2     = instruction_i[24:20];
      dec.rd      = instruction_i[11:7];
      dec.op      = OpAdd;
      dec.fu      = FuNone;
      dec.illegal = 1'b0;

      case (opc)
         OpcOp: begin
            case (f7)
               F7Base: begin
                  legal  = 1'b1;
                  dec.fu = FuAlu;
                  case (f3)
                     3'b000:  dec.op = OpAdd;
                     3'b001:  dec.op = OpSll;
                     3'b010:  dec.op = OpSlts;
                     3'b011:  dec.op = OpSltu;
                     3'b100:  dec.op = OpXorl;
                     3'b101:  dec.op = OpSrl;
                     3'b110:  dec.op = OpOrl;
                     default: dec.op = OpAndl;
                  endcase
               end
               F7Alt: begin
                  dec.fu = FuAlu;
                  if (f3 == 3'b000) begin
                     legal  = 1'b1;
                     dec.op = OpSub;
                  end else if (f3 == 3'b101) begin
                     legal  = 1'b1;
                     dec.op = OpSra;
                  end
               end
               F7MulDiv: begin
                  legal  = 1'b1;
                  dec.fu = FuMult;
                  case (f3)
                     3'b000:  dec.op = OpMul;
                     3'b001:  dec.op = OpMulh;
                     3'b010:  dec.op = OpMulhsu;
                     3'b011:  dec.op = OpMulhu;
                     3'b100:  dec.op = OpDiv;
                     3'b101:  dec.op = OpDivu;
                     3'b110:  dec.op = OpRem;
                     default: dec.op = OpRemu;
                  endcase
               end
               default: ;
            endcase
         end

         OpcOp32: begin
            dec.fu  = FuAlu;
            dec.rs2 = 5'd0;
            if (f3 == 3'b000) begin
               legal  = 1'b1;
               dec.op = OpAddw;
            end else if (f3 == 3'b001 && f7 == F7Base) begin
               legal  = 1'b1;
               dec.op = OpSllw;
            end else if (f3 == 3'b101 && f7 == F7Base) begin
               legal  = 1'b1;
               dec.op = OpSrlw;
            end else if (f3 == 3'b101 && f7 == F7Alt) begin
               legal  = 1'b1;
               dec.op = OpSraw;
            end
         end

         OpcLoad: begin
            dec.fu  = FuLoad;
            dec.rs2 = 5'd0;
            legal   = 1'b1;
            case (f3)
               3'b000:  dec.op = OpLb;
               3'b001:  dec.op = OpLh;
               3'b010:  dec.op = OpLw;
               3'b011:  dec.op = OpLd;
               3'b100:  dec.op = OpLbu;
               3'b101:  dec.op = OpLhu;
               3'b110:  dec.op = OpLwu;
               default: legal  = 1'b0;
            endcase
         end

         OpcStore: begin
            dec.fu = FuStore;
            dec.rd = 5'd0;
            legal  = !f3[2];
            case (f3[1:0])
               2'b00:   dec.op = OpSb;
               2'b01:   dec.op = OpSh;
               2'b10:   dec.op = OpSw;
               default: dec.op = OpSd;
            endcase
         end

         default: ;
      endcase

      // Illegal encodings carry no operands so nothing downstream reads stale registers.
      if (!legal) begin
         dec.rs1     = 5'd0;
         dec.rs2     = 5'd0;
         dec.rd      = 5'd0;
         dec.op      = OpAdd;
         dec.fu      = FuNone;
         dec.illegal = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign instr_ready_o = (count_q != CntW'(DEPTH));
   assign out_valid_o   = (count_q != '0);

   // Flush wins over both handshakes in the same cycle.
   assign push = instr_valid_i && instr_ready_o && !flush_i;
   assign pop  = out_valid_o && out_ready_i && !flush_i;

   // ------------------------------------------------------------------
   // Queue storage, pointers, occupancy and statistics
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= EmptyEntry;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         decoded_cnt_q <= '0;
         illegal_cnt_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= dec;
            // DEPTH is a power of two, so the pointer wraps on overflow.
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            if (decoded_cnt_q != {CNT_W{1'b1}}) begin
               decoded_cnt_q <= decoded_cnt_q + CNT_W'(1);
            end
            if (dec.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
               illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
            end
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Head entry outputs
   // ------------------------------------------------------------------
   assign head          = mem_q[rd_ptr_q];
   assign out_pc_o      = head.pc;
   assign out_rs1_o     = head.rs1;
   assign out_rs2_o     = head.rs2;
   assign out_rd_o      = head.rd;
   assign out_op_o      = head.op;
   assign out_fu_o      = head.fu;
   assign out_illegal_o = head.illegal;

   assign count_o       = count_q;
   assign decoded_cnt_o = decoded_cnt_q;
   assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed pushes record their expected decoded entry in a
// scoreboard queue; a negedge monitor compares every presented head entry.
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam logic [6:0] OP   = 7'b0110011;
   localparam logic [6:0] OP32 = 7'b0011011;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] ST   = 7'b0100011;

   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      fu_op        op;
      fu_t         fu;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        ivalid;
   logic        iready;
   logic [31:0] instr;
   logic [63:0] pc;
   logic        ovalid;
   logic        oready;
   logic [63:0] opc_out;
   logic [4:0]  ors1, ors2, ord;
   fu_op        oop;
   fu_t         ofu;
   logic        oill;
   logic [2:0]  count;
   logic [15:0] dec_cnt, ill_cnt;

   // Second instance with 2-bit counters to observe saturation.
   logic        s_iready, s_ovalid, s_oill;
   logic [63:0] s_pc;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   fu_op        s_op;
   fu_t         s_fu;
   logic [2:0]  s_count;
   logic [1:0]  s_dec_cnt, s_ill_cnt;

   int   checks = 0;
   int   passes = 0;
   int   exp_dec = 0;
   int   exp_ill = 0;
   logic [63:0] pc_next = 64'h8000_0000;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush_i(flush),
      .instr_valid_i(ivalid), .instr_ready_o(iready),
      .instruction_i(instr), .pc_i(pc),
      .out_valid_o(ovalid), .out_ready_i(oready),
      .out_pc_o(opc_out), .out_rs1_o(ors1), .out_rs2_o(ors2), .out_rd_o(ord),
      .out_op_o(oop), .out_fu_o(ofu), .out_illegal_o(oill),
      .count_o(count), .decoded_cnt_o(dec_cnt), .illegal_cnt_o(ill_cnt)
   );

   decode_queue #(.DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .flush_i(flush),
      .instr_valid_i(ivalid), .instr_ready_o(s_iready),
      .instruction_i(instr), .pc_i(pc),
      .out_valid_o(s_ovalid), .out_ready_i(oready),
      .out_pc_o(s_pc), .out_rs1_o(s_rs1), .out_rs2_o(s_rs2), .out_rd_o(s_rd),
      .out_op_o(s_op), .out_fu_o(s_fu), .out_illegal_o(s_oill),
      .count_o(s_count), .decoded_cnt_o(s_dec_cnt), .illegal_cnt_o(s_ill_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // Called at posedge+1; drives one push for a cycle and returns at the next posedge+1.
   task automatic push(input logic [31:0] ins, input bit acc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input fu_op op,
                       input fu_t fu, input logic ill);
      exp_t e;
      instr  = ins;
      pc     = pc_next;
      ivalid = 1'b1;
      if (acc) begin
         e = '{pc: pc_next, rs1: rs1, rs2: rs2, rd: rd, op: op, fu: fu, ill: ill};
         exp_q.push_back(e);
         exp_dec++;
         if (ill) exp_ill++;
      end
      pc_next = pc_next + 64'd4;
      @(posedge clk);
      #1 ivalid = 1'b0;
   endtask

   // Scoreboard monitor: every presented head must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && ovalid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_head", 64'(ovalid), 64'd0);
         end else begin
            check("head_pc", opc_out, exp_q[0].pc);
            check("head_rs1", 64'(ors1), 64'(exp_q[0].rs1));
            check("head_rs2", 64'(ors2), 64'(exp_q[0].rs2));
            check("head_rd", 64'(ord), 64'(exp_q[0].rd));
            check("head_op", 64'(oop), 64'(exp_q[0].op));
            check("head_fu", 64'(ofu), 64'(exp_q[0].fu));
            check("head_illegal", 64'(oill), 64'(exp_q[0].ill));
            if (oready && !flush) void'(exp_q.pop_front());
         end
      end
   end

   task automatic check_counters(input string tag);
      check({tag, "_decoded_cnt"}, 64'(dec_cnt), 64'(exp_dec));
      check({tag, "_illegal_cnt"}, 64'(ill_cnt), 64'(exp_ill));
      check({tag, "_sat_decoded_cnt"}, 64'(s_dec_cnt), 64'(sat3(exp_dec)));
      check({tag, "_sat_illegal_cnt"}, 64'(s_ill_cnt), 64'(sat3(exp_ill)));
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; ivalid = 1'b0; instr = '0; pc = '0; oready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(ovalid), 64'd0);
      check("rst_instr_ready", 64'(iready), 64'd1);
      #2 reset = 1'b0;

      // Idle state after reset.
      @(negedge clk);
      check("idle_out_valid", 64'(ovalid), 64'd0);
      check("idle_instr_ready", 64'(iready), 64'd1);
      check("idle_count", 64'(count), 64'd0);
      check("idle_fu", 64'(ofu), 64'(FuNone));
      check("idle_op", 64'(oop), 64'(OpAdd));
      check("idle_illegal", 64'(oill), 64'd0);
      check("idle_pc", opc_out, 64'd0);
      check("idle_rd", 64'(ord), 64'd0);
      check_counters("idle");

      // ADD x10,x10,x11 at 0x80000000; visible one edge later.
      @(posedge clk); #1;
      push(32'h00B5_0533, 1'b1, 5'd10, 5'd11, 5'd10, OpAdd, FuAlu, 1'b0);
      @(negedge clk);
      check("add_out_valid", 64'(ovalid), 64'd1);
      check("add_count", 64'(count), 64'd1);

      // Fill: SD, all-ones illegal, MUL.
      @(posedge clk); #1;
      push(32'h00B5_3023, 1'b1, 5'd10, 5'd11, 5'd0, OpSd, FuStore, 1'b0);
      push(32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, OpAdd, FuNone, 1'b1);
      push(enc(7'b0000001, 5'd12, 5'd11, 3'b000, 5'd12, OP), 1'b1,
           5'd11, 5'd12, 5'd12, OpMul, FuMult, 1'b0);
      @(negedge clk);
      check("full_count", 64'(count), 64'd4);
      check("full_instr_ready", 64'(iready), 64'd0);
      check_counters("full");

      // Fifth push must be refused.
      @(posedge clk); #1;
      push(enc(7'b0100000, 5'd3, 5'd4, 3'b101, 5'd5, OP), 1'b0,
           5'd0, 5'd0, 5'd0, OpAdd, FuNone, 1'b0);
      @(negedge clk);
      check("over_count", 64'(count), 64'd4);
      check("over_instr_ready", 64'(iready), 64'd0);
      check_counters("over");

      // Single pop frees a slot.
      @(posedge clk); #1 oready = 1'b1;
      @(posedge clk); #1 oready = 1'b0;
      @(negedge clk);
      check("pop_count", 64'(count), 64'd3);
      check("pop_instr_ready", 64'(iready), 64'd1);

      // Flush with a simultaneous push: queue empties, counters untouched.
      @(posedge clk); #1;
      flush = 1'b1; ivalid = 1'b1; instr = 32'h00B5_0533;
      @(posedge clk); #1;
      flush = 1'b0; ivalid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(ovalid), 64'd0);
      check_counters("flush");

      // Streaming push+pop every cycle; pointers wrap several times.
      @(posedge clk); #1 oready = 1'b1;
      push(enc(7'b0100000, 5'd7, 5'd6, 3'b000, 5'd5, OP), 1'b1, 5'd6, 5'd7, 5'd5, OpSub, FuAlu, 1'b0);
      push(enc(7'b0000000, 5'd3, 5'd2, 3'b011, 5'd1, OP), 1'b1, 5'd2, 5'd3, 5'd1, OpSltu, FuAlu, 1'b0);
      push(enc(7'b0000000, 5'd9, 5'd8, 3'b100, 5'd7, OP), 1'b1, 5'd8, 5'd9, 5'd7, OpXorl, FuAlu, 1'b0);
      push(enc(7'b0100000, 5'd9, 5'd8, 3'b101, 5'd7, OP), 1'b1, 5'd8, 5'd9, 5'd7, OpSra, FuAlu, 1'b0);
      push(enc(7'b0100000, 5'd9, 5'd8, 3'b001, 5'd7, OP), 1'b1, 5'd0, 5'd0, 5'd0, OpAdd, FuNone, 1'b1);
      push(enc(7'b0000000, 5'd9, 5'd8, 3'b000, 5'd4, OP32), 1'b1, 5'd8, 5'd0, 5'd4, OpAddw, FuAlu, 1'b0);
      push(enc(7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, OP32), 1'b1, 5'd2, 5'd0, 5'd1, OpSraw, FuAlu, 1'b0);
      push(enc(7'b0100000, 5'd3, 5'd2, 3'b001, 5'd1, OP32), 1'b1, 5'd0, 5'd0, 5'd0, OpAdd, FuNone, 1'b1);
      push(enc(7'b0000000, 5'd17, 5'd15, 3'b011, 5'd14, LD), 1'b1, 5'd15, 5'd0, 5'd14, OpLd, FuLoad, 1'b0);
      push(enc(7'b0000000, 5'd17, 5'd15, 3'b100, 5'd14, LD), 1'b1, 5'd15, 5'd0, 5'd14, OpLbu, FuLoad, 1'b0);
      push(enc(7'b0000000, 5'd17, 5'd15, 3'b111, 5'd14, LD), 1'b1, 5'd0, 5'd0, 5'd0, OpAdd, FuNone, 1'b1);
      push(enc(7'b0000000, 5'd20, 5'd21, 3'b000, 5'd22, ST), 1'b1, 5'd21, 5'd20, 5'd0, OpSb, FuStore, 1'b0);
      push(enc(7'b0000000, 5'd20, 5'd21, 3'b100, 5'd22, ST), 1'b1, 5'd0, 5'd0, 5'd0, OpAdd, FuNone, 1'b1);
      push(enc(7'b0000001, 5'd31, 5'd30, 3'b011, 5'd29, OP), 1'b1, 5'd30, 5'd31, 5'd29, OpMulhu, FuMult, 1'b0);
      push(enc(7'b0000001, 5'd1, 5'd2, 3'b111, 5'd3, OP), 1'b1, 5'd2, 5'd1, 5'd3, OpRemu, FuMult, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("drain_count", 64'(count), 64'd0);
      check("drain_out_valid", 64'(ovalid), 64'd0);
      check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
      check_counters("drain");

      // Asynchronous reset mid-operation empties the queue without a clock edge.
      @(posedge clk); #1 oready = 1'b0;
      push(32'h00B5_0533, 1'b1, 5'd10, 5'd11, 5'd10, OpAdd, FuAlu, 1'b0);
      push(32'h00B5_3023, 1'b1, 5'd10, 5'd11, 5'd0, OpSd, FuStore, 1'b0);
      check("pre_reset_count", 64'(count), 64'd2);
      #2 reset = 1'b1;
      #1;
      check("async_rst_count", 64'(count), 64'd0);
      check("async_rst_out_valid", 64'(ovalid), 64'd0);
      check("async_rst_instr_ready", 64'(iready), 64'd1);
      exp_q.delete();
      exp_dec = 0;
      exp_ill = 0;
      check_counters("async_rst");
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", 64'(ovalid), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001: Parameter DEPTH, default 4, is the entry count of the decoded-instruction queue (power of 2, >=2).
REQ-002: Parameter CNT_W, default 16, is the width of the statistics counters.
REQ-003: The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004: clk  in  1  clock, all state on rising edge.
REQ-005: reset  in  1  asynchronous, active-high reset.
REQ-006: flush_i  in  1  discard all queued entries.
REQ-007: instr_valid_i / instr_ready_o  in/out  1/1  input handshake.
REQ-008: instruction_i  in  32  uncompressed RV64 instruction.
REQ-009: pc_i  in  64  PC of instruction_i.
REQ-010: out_valid_o / out_ready_i  out/in  1/1  output handshake.
REQ-011: out_pc_o  out  64  PC of head entry.
REQ-012: out_rs1_o, out_rs2_o, out_rd_o  out  5 each  register indices of head entry.
REQ-013: out_op_o  out  fu_op  operation; out_fu_o  out  fu_t  functional unit.
REQ-014: out_illegal_o  out  1  head entry is an illegal instruction.
REQ-015: count_o  out  $clog2(DEPTH+1)  occupied entries.
REQ-016: decoded_cnt_o, illegal_cnt_o  out  CNT_W each  accepted / illegal instruction counts.

Function
REQ-017: The block SHALL accept an instruction when instr_valid_i && instr_ready_o && !flush_i; instr_ready_o = (count_o != DEPTH).
REQ-018: The block SHALL decode combinationally at acceptance and store pc, rs1, rs2, rd, op, fu, illegal in the tail entry.
REQ-019: Opcode 0110011, funct7 0000000, funct3 000..111 SHALL decode to ADD, SLL, SLTS, SLTU, XORL, SRL, ORL, ANDL with fu ALU.
REQ-020: Opcode 0110011, funct7 0100000 SHALL decode funct3 000 to SUB and 101 to SRA (fu ALU); other funct3 values are illegal.
REQ-021: Opcode 0110011, funct7 0000001, funct3 000..111 SHALL decode to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with fu MULT.
REQ-022: Opcode 0011011 SHALL decode funct3 000 to ADDW, 001/funct7 0 to SLLW, 101/funct7 0 to SRLW, 101/funct7 0100000 to SRAW (fu ALU, rs2=0); all else is illegal.
REQ-023: Opcode 0000011, funct3 000..110 SHALL decode to LB, LH, LW, LD, LBU, LHU, LWU (fu LOAD, rs2=0); funct3 111 is illegal.
REQ-024: Opcode 0100011, funct3 000..011 SHALL decode to SB, SH, SW, SD (fu STORE, rd=0); funct3 1xx is illegal.
REQ-025: Register fields SHALL come from instruction bits [19:15] rs1, [24:20] rs2, [11:7] rd unless zeroed above.
REQ-026: Any other encoding SHALL be illegal: illegal=1, fu NONE, op ADD, rs1=rs2=rd=0.
REQ-027: An entry accepted at edge N SHALL be visible at the head (out_valid_o=1) after edge N when the queue was empty (1-cycle latency).
REQ-028: out_valid_o SHALL equal (count_o != 0); the head pops when out_valid_o && out_ready_i.
REQ-029: Simultaneous push and pop SHALL leave count_o unchanged and preserve FIFO order.
REQ-030: Read and write pointers SHALL wrap modulo DEPTH.
REQ-031: Output fields SHALL be held stable while out_valid_o && !out_ready_i.
REQ-032: flush_i SHALL, at the next edge, zero pointers and count_o, drop any push and pop in that cycle, and leave counters unchanged.
REQ-033: decoded_cnt_o SHALL increment per accepted instruction; illegal_cnt_o per accepted illegal instruction; both saturate at 2^CNT_W-1.

Reset
REQ-034: Reset SHALL asynchronously zero pointers, count_o, both counters, and all entry storage.
REQ-035: During/after reset out_valid_o=0, instr_ready_o=1, out_fu_o=NONE, out_op_o=ADD, out_illegal_o=0, other outputs 0.
REQ-036: Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-037: Reset -> out_valid_o=0, instr_ready_o=1, count_o=0, decoded_cnt_o=illegal_cnt_o=0.
REQ-038: Push 0x00B50533 at pc 0x80000000 -> next cycle out_valid_o=1, rs1=10, rs2=11, rd=10, op ADD, fu ALU, out_pc_o=0x80000000.
REQ-039: Push 0x00B53023 -> rs1=10, rs2=11, rd=0, op SD, fu STORE, illegal=0.
REQ-040: DEPTH=4, out_ready_i=0, 5 pushes -> instr_ready_o=0 after 4th, 5th not accepted, count_o=4; one pop -> instr_ready_o=1 next cycle.
REQ-041: Push 0xFFFFFFFF -> out_illegal_o=1, fu NONE, op ADD, illegal_cnt_o=1; with CNT_W=2, 5 pushes -> decoded_cnt_o=3.
REQ-042: 3 entries queued, flush_i with simultaneous push -> count_o=0, out_valid_o=0 next cycle, decoded_cnt_o unchanged.
